// File: rtl/pulse_id_uart_tx_pkg.sv
// Shared constants, FSM encodings and byte helpers for the pulse-id UART frame.
package pulse_id_uart_tx_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         FRAME_LEN   = 14;
  localparam int         VAL_W       = 17;
  localparam int         IDX_W       = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    HANDSHAKE,
    LOAD,
    SEND,
    NEXT
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_phase_t;

  // k=0 is the MSB byte holding only bit 16, k=2 the LSB byte.
  function automatic logic [7:0] val_byte(input logic [VAL_W-1:0] v, input logic [1:0] k);
    case (k)
      2'd0:    val_byte = {7'b0, v[16]};
      2'd1:    val_byte = v[15:8];
      default: val_byte = v[7:0];
    endcase
  endfunction

  // XOR of the three bytes a value occupies in the frame.
  function automatic logic [7:0] val_xor(input logic [VAL_W-1:0] v);
    val_xor = {7'b0, v[16]} ^ v[15:8] ^ v[7:0];
  endfunction

endpackage

// File: rtl/pulse_id_uart_tx_uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit.
// done is high during the final cycle of the stop bit so the caller can
// queue the next byte with a short gap.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 625
) (
  input  logic       clk_72MHz,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       done
);
  import pulse_id_uart_tx_pkg::*;

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  tx_phase_t        r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_cnt_zero;
  logic             w_done;

  assign w_cnt_zero = (r_cnt == '0);
  assign tx         = r_tx;
  assign done       = w_done;

  // Serializer state and bit/baud counter registers.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_phase   <= TX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_phase   <= w_phase_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next-state logic: each bit is held until the baud down-counter hits zero.
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_done      = 1'b0;
    if (r_phase != TX_IDLE && !w_cnt_zero) w_cnt_nxt = r_cnt - 1'b1;
    case (r_phase)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_start) begin
          w_phase_nxt = TX_START;
          w_tx_nxt    = 1'b0;
          w_cnt_nxt   = CNT_MAX;
          w_shift_nxt = tx_data;
          w_bit_nxt   = '0;
        end
      end
      TX_START: begin
        if (w_cnt_zero) begin
          w_phase_nxt = TX_DATA;
          w_tx_nxt    = r_shift[0];
          w_cnt_nxt   = CNT_MAX;
        end
      end
      TX_DATA: begin
        if (w_cnt_zero) begin
          w_cnt_nxt = CNT_MAX;
          if (r_bit_idx == 3'd7) begin
            w_phase_nxt = TX_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_idx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (w_cnt_zero) begin
          w_done      = 1'b1;
          w_phase_nxt = TX_IDLE;
        end
      end
      default: w_phase_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/pulse_id_uart_tx.sv
// Captures a pulse-identification result, acknowledges it, and sends it as a
// 14-byte UART frame: header, polynomial, three pulse ids, XOR checksum.
module pulse_id_uart_tx #(
  parameter int         CLKS_PER_BIT = 625,
  parameter logic [7:0] HEADER_BYTE  = pulse_id_uart_tx_pkg::HEADER_BYTE
) (
  input  logic                                  clk_72MHz,
  input  logic                                  reset,
  input  logic                                  ready,
  input  logic [pulse_id_uart_tx_pkg::VAL_W-1:0] polynomial,
  input  logic [pulse_id_uart_tx_pkg::VAL_W-1:0] pulse_id_0,
  input  logic [pulse_id_uart_tx_pkg::VAL_W-1:0] pulse_id_1,
  input  logic [pulse_id_uart_tx_pkg::VAL_W-1:0] pulse_id_2,
  output logic                                  id_ack,
  output logic                                  tx,
  output logic                                  busy
);
  import pulse_id_uart_tx_pkg::*;

  state_t           r_state, w_state_nxt;
  logic             r_id_ack, r_busy;
  logic [IDX_W-1:0] r_idx;
  logic [VAL_W-1:0] r_poly, r_id0, r_id1, r_id2;
  logic             w_tx_start, w_done;
  logic [7:0]       w_byte, w_checksum;

  assign id_ack     = r_id_ack;
  assign busy       = r_busy;
  assign w_checksum = val_xor(r_poly) ^ val_xor(r_id0) ^ val_xor(r_id1) ^ val_xor(r_id2);

  // Byte selection from the shadow registers by frame index.
  always_comb begin
    w_byte = w_checksum;
    if (r_idx == 4'd0)       w_byte = HEADER_BYTE;
    else if (r_idx <= 4'd3)  w_byte = val_byte(r_poly, 2'(r_idx - 4'd1));
    else if (r_idx <= 4'd6)  w_byte = val_byte(r_id0, 2'(r_idx - 4'd4));
    else if (r_idx <= 4'd9)  w_byte = val_byte(r_id1, 2'(r_idx - 4'd7));
    else if (r_idx <= 4'd12) w_byte = val_byte(r_id2, 2'(r_idx - 4'd10));
  end

  // State register plus handshake, busy, index and shadow updates.
  always_ff @(posedge clk_72MHz) begin
    if (reset) begin
      r_state  <= IDLE;
      r_id_ack <= 1'b0;
      r_busy   <= 1'b0;
      r_idx    <= '0;
      r_poly   <= '0;
      r_id0    <= '0;
      r_id1    <= '0;
      r_id2    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (ready && !r_id_ack) r_busy <= 1'b1;
        CAPTURE: begin
          r_poly   <= polynomial;
          r_id0    <= pulse_id_0;
          r_id1    <= pulse_id_1;
          r_id2    <= pulse_id_2;
          r_id_ack <= 1'b1;
        end
        HANDSHAKE: begin
          if (!ready) begin
            r_id_ack <= 1'b0;
            r_idx    <= '0;
          end
        end
        NEXT: begin
          if (r_idx == LAST_IDX) r_busy <= 1'b0;
          else                   r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and the one-cycle serializer start strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_start  = 1'b0;
    case (r_state)
      IDLE:      if (ready && !r_id_ack) w_state_nxt = CAPTURE;
      CAPTURE:   w_state_nxt = HANDSHAKE;
      HANDSHAKE: if (!ready) w_state_nxt = LOAD;
      LOAD: begin
        w_tx_start  = 1'b1;
        w_state_nxt = SEND;
      end
      SEND:      if (w_done) w_state_nxt = NEXT;
      NEXT:      w_state_nxt = (r_idx == LAST_IDX) ? IDLE : LOAD;
      default:   w_state_nxt = IDLE;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_72MHz(clk_72MHz),
    .reset    (reset),
    .tx_start (w_tx_start),
    .tx_data  (w_byte),
    .tx       (tx),
    .done     (w_done)
  );

endmodule

// File: tb/tb_pulse_id_uart_tx.sv
// Bench for pulse_id_uart_tx: expected frame bytes are queued when a result
// is offered and compared as the UART receiver below decodes each byte.
module tb_pulse_id_uart_tx;

  localparam int CPB    = 16;
  localparam int BUDGET = 14 * 10 * CPB + 200;

  logic        clk_72MHz = 1'b0;
  logic        reset;
  logic        ready;
  logic [16:0] polynomial, pulse_id_0, pulse_id_1, pulse_id_2;
  logic        id_ack, tx, busy;

  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int bpos = 0;
  int rx_cnt = 0;
  int max_gap = 0;
  bit in_byte = 1'b0;

  always #7 clk_72MHz = ~clk_72MHz;

  pulse_id_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk_72MHz (clk_72MHz),
    .reset     (reset),
    .ready     (ready),
    .polynomial(polynomial),
    .pulse_id_0(pulse_id_0),
    .pulse_id_1(pulse_id_1),
    .pulse_id_2(pulse_id_2),
    .id_ack    (id_ack),
    .tx        (tx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [16:0] p, a, b, c);
    logic [16:0] v[4];
    logic [7:0]  ck;
    logic [7:0]  bt[3];
    v[0] = p; v[1] = a; v[2] = b; v[3] = c;
    ck = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      bt[0] = {7'b0, v[i][16]};
      bt[1] = v[i][15:8];
      bt[2] = v[i][7:0];
      for (int j = 0; j < 3; j++) begin
        exp_q.push_back(bt[j]);
        ck = ck ^ bt[j];
      end
    end
    exp_q.push_back(ck);
  endtask

  task automatic handshake(input bit chk_lat);
    int n, w;
    n = 0;
    while (!id_ack && n < 20) begin @(negedge clk_72MHz); n++; end
    chk("ack_rise", 32'(id_ack), 1);
    if (chk_lat) chk("ack_latency", n, 2);
    ready = 1'b0;
    polynomial = 17'($urandom);
    pulse_id_0 = 17'($urandom);
    pulse_id_1 = 17'($urandom);
    pulse_id_2 = 17'($urandom);
    w = 0;
    while (id_ack && w < 20) begin @(negedge clk_72MHz); w++; end
    chk("ack_width", w, 1);
    chk("busy_held", 32'(busy), 1);
  endtask

  task automatic send(input logic [16:0] p, a, b, c, input bit early);
    @(negedge clk_72MHz);
    polynomial = p; pulse_id_0 = a; pulse_id_1 = b; pulse_id_2 = c;
    ready = 1'b1;
    push_frame(p, a, b, c);
    if (early) begin
      @(negedge clk_72MHz);
      ready = 1'b0;
    end
    handshake(!early);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < BUDGET) begin @(negedge clk_72MHz); n++; end
    chk("frame_done", 32'(exp_q.size() == 0 && !busy), 1);
    chk("idle_tx", 32'(tx), 1);
    chk("gap_le2", 32'(max_gap <= 2), 1);
    max_gap = 0;
  endtask

  // UART receiver: samples the first and last cycle of every bit.
  initial begin : rx_mon
    logic       prev;
    bit         ab;
    int         idle_cnt;
    logic [9:0] fs, ls, ef;
    logic [7:0] eb;
    prev = 1'b1;
    idle_cnt = 0;
    forever begin
      @(negedge clk_72MHz);
      if (reset === 1'b1) begin
        prev = 1'b1; bpos = 0; in_byte = 1'b0; idle_cnt = 0;
      end else if (prev === 1'b1 && tx === 1'b0) begin
        if (bpos != 0 && idle_cnt > max_gap) max_gap = idle_cnt;
        in_byte = 1'b1;
        ab = 1'b0;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk_72MHz);
          if (reset === 1'b1) begin ab = 1'b1; break; end
          if (c % CPB == 0)       fs[c / CPB] = tx;
          if (c % CPB == CPB - 1) ls[c / CPB] = tx;
        end
        in_byte = 1'b0;
        idle_cnt = 0;
        prev = 1'b1;
        if (ab) bpos = 0;
        else begin
          chk("rx_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            ef = {1'b1, eb, 1'b0};
            chk("rx_frame", 32'({fs, ls}), 32'({ef, ef}));
          end
          rx_cnt++;
          bpos = (bpos == 13) ? 0 : bpos + 1;
        end
      end else begin
        prev = tx;
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #(14 * 60000);
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, acks, cnt0;
    reset = 1'b1; ready = 1'b0;
    polynomial = '0; pulse_id_0 = '0; pulse_id_1 = '0; pulse_id_2 = '0;
    repeat (3) @(negedge clk_72MHz);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(id_ack), 0);
    reset = 1'b0;

    send(17'h0, 17'h0, 17'h0, 17'h0, 1'b0);
    wait_frame();
    send(17'h0, 17'h1FFFF, 17'h0, 17'h0, 1'b1);
    wait_frame();
    send(17'h0D8E5, 17'h0, 17'h12345, 17'h0, 1'b0);
    wait_frame();

    // second result offered while a frame is in flight
    send(17'h1ABCD, 17'h00F0F, 17'h10001, 17'h0FFFF, 1'b0);
    repeat (1000) @(negedge clk_72MHz);
    polynomial = 17'h05555; pulse_id_0 = 17'h1AAAA; pulse_id_1 = 17'h00123; pulse_id_2 = 17'h1C3C3;
    ready = 1'b1;
    push_frame(17'h05555, 17'h1AAAA, 17'h00123, 17'h1C3C3);
    acks = 0; n = 0;
    while (busy && n < BUDGET) begin
      if (id_ack) acks++;
      @(negedge clk_72MHz); n++;
    end
    chk("bp_no_ack", acks, 0);
    handshake(1'b0);
    wait_frame();

    // reset in the middle of byte 5
    send(17'h13579, 17'h02468, 17'h1FEDC, 17'h00BA9, 1'b0);
    n = 0;
    while (!(in_byte && bpos == 5) && n < BUDGET) begin @(negedge clk_72MHz); n++; end
    chk("reach_byte5", 32'(in_byte && bpos == 5), 1);
    repeat (40) @(negedge clk_72MHz);
    reset = 1'b1;
    @(negedge clk_72MHz);
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk_72MHz);
    reset = 1'b0;
    exp_q.delete();
    max_gap = 0;
    cnt0 = rx_cnt;
    repeat (500) @(negedge clk_72MHz);
    chk("abort_no_tx", rx_cnt - cnt0, 0);
    chk("abort_idle", 32'(busy), 0);

    // reset while waiting for ready to drop
    @(negedge clk_72MHz);
    polynomial = 17'h1111; pulse_id_0 = 17'h2222; pulse_id_1 = 17'h3333; pulse_id_2 = 17'h4444;
    ready = 1'b1;
    n = 0;
    while (!id_ack && n < 20) begin @(negedge clk_72MHz); n++; end
    chk("hs_ack_rise", 32'(id_ack), 1);
    reset = 1'b1;
    ready = 1'b0;
    @(negedge clk_72MHz);
    chk("hs_rst_ack", 32'(id_ack), 0);
    chk("hs_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    cnt0 = rx_cnt;
    repeat (300) @(negedge clk_72MHz);
    chk("hs_no_tx", rx_cnt - cnt0, 0);

    send(17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom), 1'b0);
    wait_frame();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_id_uart_tx.md
PULSE_ID_UART_TX -- requirements
Module: pulse_id_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, 625, clk_72MHz cycles per UART bit (115200 baud).
REQ-002 Parameter HEADER_BYTE, 8'hA5, first byte of every frame.
REQ-003 clk_72MHz  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high block reset.
REQ-005 ready  input  1  pulse-identification result valid; held high until acknowledged.
REQ-006 polynomial  input  17  identified polynomial, valid while ready=1.
REQ-007 pulse_id_0 / pulse_id_1 / pulse_id_2  input  17 each  per-sensor pulse ids, valid while ready=1.
REQ-008 id_ack  output  1  drives the identifier's result-consume (reset) input.
REQ-009 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high from capture until the last stop bit completes.

Function
REQ-011 The main FSM SHALL have exactly the states IDLE, CAPTURE, HANDSHAKE, LOAD, SEND and NEXT.
REQ-012 IDLE: when ready=1 and id_ack=0, the FSM SHALL go to CAPTURE. ready=1 seen in any other state SHALL NOT be sampled (backpressure; no frame dropped, no ack issued).
REQ-013 CAPTURE: the block SHALL latch polynomial and pulse_id_0..2 into shadow registers, set busy=1, assert id_ack on the next cycle, and go to HANDSHAKE.
REQ-014 HANDSHAKE: id_ack SHALL stay high until ready is sampled low; on the following cycle id_ack SHALL go low and the FSM SHALL go to LOAD with byte index 0.
REQ-015 Frame format: 14 bytes in this order: HEADER_BYTE; polynomial; pulse_id_0; pulse_id_1; pulse_id_2; checksum.
REQ-016 Each 17-bit value SHALL be sent as 3 bytes: {7'b0, v[16]}, v[15:8], v[7:0].
REQ-017 The checksum SHALL be the XOR of bytes 1..12; the header SHALL be excluded.
REQ-018 LOAD: the block SHALL present the byte and pulse tx_start to the byte serializer for 1 cycle, then go to SEND.
REQ-019 SEND: the FSM SHALL wait for serializer done, then go to NEXT.
REQ-020 NEXT: if the index is 13, the FSM SHALL clear busy and go to IDLE; otherwise it SHALL increment the index and go to LOAD.
REQ-021 Serializer: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles; done pulses 1 cycle at the end of the stop bit.
REQ-022 Frame length SHALL be 14 x 10 x CLKS_PER_BIT cycles plus at most 2 cycles of gap per byte; with default parameters this is 87500 cycles plus at most 28 cycles.
REQ-023 Shadow registers SHALL NOT change between CAPTURE and return to IDLE, even if the inputs change.
REQ-024 If ready is already low on the cycle after id_ack rises, id_ack SHALL still be high for at least 1 cycle.

Reset
REQ-025 On reset=1 the block SHALL set: FSM=IDLE, id_ack=0, busy=0, tx=1, serializer idle, byte index=0, bit/baud counters=0, shadow registers=0.
REQ-026 Reset mid-frame SHALL abort transmission: tx=1 on the next cycle. No partial resumption SHALL occur, and the aborted frame SHALL NOT be resent.
REQ-027 Reset during HANDSHAKE SHALL drop id_ack on the next cycle.

Structure
REQ-028 A shared package SHALL hold HEADER_BYTE, the frame length (14), the FSM state encoding and the 17-bit value width.
REQ-029 The byte serializer SHALL be one sub-module, uart_byte_tx (ports: clk_72MHz, reset, tx_start, tx_data[7:0], tx, done), parameterized by CLKS_PER_BIT.

Verification
REQ-030 Stimulus: poly=0, ids=0, ready pulse. Required response: bytes A5, then 12 x 00, then checksum 00; id_ack high for ≥1 cycle; busy low after the last stop bit.
REQ-031 Stimulus: pulse_id_0=17'h1FFFF, others 0. Required response: bytes 4-6 = 01 FF FF, checksum = 01.
REQ-032 Stimulus: polynomial=17'h0D8E5, pulse_id_1=17'h12345. Required response: bytes 1-3 = 00 D8 E5, bytes 7-9 = 01 23 45, checksum = 00^D8^E5^01^23^45 = 5A.
REQ-033 Stimulus: second ready raised 1000 cycles into a frame. Required response: no id_ack until the first frame ends, then a second frame with the new values.
REQ-034 Stimulus: reset asserted during byte 5. Required response: tx=1 and busy=0 on the next cycle; nothing further transmitted until a new ready.
REQ-035 Bit-timing check: every start, data and stop bit measured at exactly 625 cycles with default parameters.
